// File: rtl/store_write_combine_buffer_if.sv
// Store-commit / DCache-write / load-probe bundle of the write-combining buffer.
// The master side is the surrounding core (committer, DCache and load unit).
interface store_write_combine_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  // retired store channel
  logic                    stValid;
  logic                    stReady;
  logic [ADDR_WIDTH-1:0]   stAddr;
  logic [31:0]             stData;
  logic [3:0]              stByteWE;
  logic                    fenceReq;
  // line write channel towards the DCache
  logic                    dcWriteReq;
  logic                    dcWriteAck;
  logic [ADDR_WIDTH-1:0]   dcWriteAddr;
  logic [LINE_BYTES*8-1:0] dcWriteData;
  logic [LINE_BYTES-1:0]   dcWriteByteWE;
  // load forwarding probe
  logic [ADDR_WIDTH-1:0]   fwdAddr;
  logic                    fwdHit;
  logic [31:0]             fwdData;
  logic [3:0]              fwdByteMask;

  modport master (
    output stValid, stAddr, stData, stByteWE, fenceReq, dcWriteAck, fwdAddr,
    input  stReady, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
           fwdHit, fwdData, fwdByteMask
  );

  modport slave (
    input  stValid, stAddr, stData, stByteWE, fenceReq, dcWriteAck, fwdAddr,
    output stReady, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
           fwdHit, fwdData, fwdByteMask
  );
endinterface

// File: rtl/store_write_combine_buffer.sv
// Write-combining buffer between the store committer and the DCache write port.
// Retired stores merge into line-sized entries kept in a circular FIFO; whole
// lines drain oldest-first on occupancy threshold, idle timeout or fence.
// The head entry is locked while its write request is outstanding so the data
// handed to the DCache never changes under it; stores to that line allocate a
// fresh entry instead. Loads probe all entries for byte-level forwarding.
module store_write_combine_buffer #(
  parameter int ENTRY_NUM       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_BYTES      = 16,
  parameter int DRAIN_THRESHOLD = 2,
  parameter int IDLE_TIMEOUT    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  store_write_combine_buffer_if.slave    bus,
  output logic [$clog2(ENTRY_NUM+1)-1:0] count,
  output logic                           empty
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int LINE_W   = ADDR_WIDTH - OFF_BITS;
  localparam int WORD_W   = OFF_BITS - 2;
  localparam int PTR_W    = $clog2(ENTRY_NUM);
  localparam int CNT_W    = $clog2(ENTRY_NUM + 1);
  localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int DATA_W   = LINE_BYTES * 8;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ENTRY_NUM);
  localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(DRAIN_THRESHOLD);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drainState_t;

  // entry storage
  logic [ENTRY_NUM-1:0]  entryValid;
  logic [LINE_W-1:0]     entryLine [ENTRY_NUM];
  logic [DATA_W-1:0]     entryData [ENTRY_NUM];
  logic [LINE_BYTES-1:0] entryWE   [ENTRY_NUM];

  // FIFO control
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  countR;
  logic [CNT_W-1:0]  countNext;
  logic [IDLE_W-1:0] idleCnt;
  logic [IDLE_W-1:0] idleNext;
  logic              drainAll;
  logic              drainAllNext;
  drainState_t       state;
  drainState_t       stateNext;

  // store path
  logic [LINE_W-1:0]     stLine;
  logic [WORD_W-1:0]     stWord;
  logic                  headLocked;
  logic                  matchHit;
  logic [PTR_W-1:0]      matchIdx;
  logic [PTR_W-1:0]      tgtIdx;
  logic                  full;
  logic                  stReadyS;
  logic                  accept;
  logic                  doAlloc;
  logic                  pop;
  logic [DATA_W-1:0]     newData;
  logic [LINE_BYTES-1:0] newWE;
  logic [OFF_BITS-1:0]   stByteSel;

  // forwarding path
  logic [LINE_W-1:0]   fwdLine;
  logic [WORD_W-1:0]   fwdWord;
  logic [PTR_W-1:0]    fwdIdx;
  logic [OFF_BITS-1:0] fwdByteSel;
  logic                fwdEntryHit;
  logic                fwdTake;
  logic [31:0]         fwdDataS;
  logic [3:0]          fwdMaskS;

  logic dcWriteReqS;
  logic unusedAddrBits;

  // A line is eligible to start (or keep) draining.
  function automatic logic drainCond(input logic [CNT_W-1:0] c,
                                     input logic da,
                                     input logic [IDLE_W-1:0] ic);
    return (c != CNT_ZERO) && ((c >= CNT_THR) || da || (ic >= IDLE_MAX));
  endfunction

  assign stLine     = bus.stAddr[ADDR_WIDTH-1:OFF_BITS];
  assign stWord     = bus.stAddr[OFF_BITS-1:2];
  assign fwdLine    = bus.fwdAddr[ADDR_WIDTH-1:OFF_BITS];
  assign fwdWord    = bus.fwdAddr[OFF_BITS-1:2];
  assign headLocked = (state == REQ);
  assign full       = (countR == CNT_FULL);
  assign stReadyS   = rst && !drainAll && (matchHit || !full);
  assign accept     = bus.stValid && stReadyS;
  assign doAlloc    = accept && !matchHit;
  assign pop        = (state == REQ) && bus.dcWriteAck;
  assign tgtIdx     = matchHit ? matchIdx : tailPtr;

  // word-alignment bits of the addresses carry no information
  assign unusedAddrBits = ^{bus.stAddr[1:0], bus.fwdAddr[1:0]};

  // Find the unlocked valid entry that already holds the store's line.
  always_comb begin
    matchHit = 1'b0;
    matchIdx = {PTR_W{1'b0}};
    for (int i = 0; i < ENTRY_NUM; i++) begin
      matchIdx = (entryValid[i] && (entryLine[i] == stLine) &&
                  !(headLocked && (PTR_W'(i) == headPtr))) ? PTR_W'(i) : matchIdx;
      matchHit = matchHit | (entryValid[i] && (entryLine[i] == stLine) &&
                             !(headLocked && (PTR_W'(i) == headPtr)));
    end
  end

  // Build the updated line image: merge into the match, or start a clean line.
  always_comb begin
    newData   = matchHit ? entryData[tgtIdx] : {DATA_W{1'b0}};
    newWE     = matchHit ? entryWE[tgtIdx] : {LINE_BYTES{1'b0}};
    stByteSel = {OFF_BITS{1'b0}};
    for (int b = 0; b < 4; b++) begin
      stByteSel = {stWord, 2'(b)};
      newData[{stByteSel, 3'b000} +: 8] = bus.stByteWE[b] ? bus.stData[b*8 +: 8]
                                                          : newData[{stByteSel, 3'b000} +: 8];
      newWE[stByteSel] = newWE[stByteSel] | bus.stByteWE[b];
    end
  end

  // Forward each probed byte from the youngest entry holding it (oldest first, later wins).
  always_comb begin
    fwdDataS    = 32'h0000_0000;
    fwdMaskS    = 4'b0000;
    fwdIdx      = {PTR_W{1'b0}};
    fwdByteSel  = {OFF_BITS{1'b0}};
    fwdEntryHit = 1'b0;
    fwdTake     = 1'b0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      fwdIdx      = headPtr + PTR_W'(k);
      fwdEntryHit = entryValid[fwdIdx] && (entryLine[fwdIdx] == fwdLine);
      for (int b = 0; b < 4; b++) begin
        fwdByteSel       = {fwdWord, 2'(b)};
        fwdTake          = fwdEntryHit && entryWE[fwdIdx][fwdByteSel];
        fwdDataS[b*8 +: 8] = fwdTake ? entryData[fwdIdx][{fwdByteSel, 3'b000} +: 8]
                                     : fwdDataS[b*8 +: 8];
        fwdMaskS[b]      = fwdMaskS[b] | fwdTake;
      end
    end
  end

  // Next occupancy, idle counter and fence flag.
  always_comb begin
    countNext = countR + CNT_W'(doAlloc) - CNT_W'(pop);
    if (accept || pop) begin
      idleNext = IDLE_ZERO;
    end else if (countR == CNT_ZERO) begin
      idleNext = IDLE_ZERO;
    end else if (idleCnt < IDLE_MAX) begin
      idleNext = idleCnt + IDLE_W'(1'b1);
    end else begin
      idleNext = idleCnt;
    end
    if (countNext == CNT_ZERO) begin
      drainAllNext = 1'b0;
    end else if (bus.fenceReq && (countR != CNT_ZERO)) begin
      drainAllNext = 1'b1;
    end else begin
      drainAllNext = drainAll;
    end
  end

  // Drain FSM next state; after a pop, decide on the post-pop occupancy.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = drainCond(countR, drainAll, idleCnt) ? REQ : IDLE;
      REQ:     stateNext = pop ? (drainCond(countNext, drainAllNext, idleNext) ? REQ : IDLE)
                               : REQ;
      default: stateNext = IDLE;
    endcase
  end

  // Drain FSM outputs: request only while in REQ.
  always_comb begin
    dcWriteReqS = 1'b0;
    case (state)
      IDLE:    dcWriteReqS = 1'b0;
      REQ:     dcWriteReqS = 1'b1;
      default: dcWriteReqS = 1'b0;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FIFO pointers, occupancy, idle counter and fence flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr  <= {PTR_W{1'b0}};
      tailPtr  <= {PTR_W{1'b0}};
      countR   <= CNT_ZERO;
      idleCnt  <= IDLE_ZERO;
      drainAll <= 1'b0;
    end else begin
      if (pop) begin
        headPtr <= headPtr + PTR_W'(1'b1);
      end
      if (doAlloc) begin
        tailPtr <= tailPtr + PTR_W'(1'b1);
      end
      countR   <= countNext;
      idleCnt  <= idleNext;
      drainAll <= drainAllNext;
    end
  end

  // Entry storage: retire the popped head, write the merged/allocated line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entryValid <= {ENTRY_NUM{1'b0}};
      for (int i = 0; i < ENTRY_NUM; i++) begin
        entryLine[i] <= {LINE_W{1'b0}};
        entryData[i] <= {DATA_W{1'b0}};
        entryWE[i]   <= {LINE_BYTES{1'b0}};
      end
    end else begin
      if (pop) begin
        entryValid[headPtr] <= 1'b0;
      end
      if (accept) begin
        entryValid[tgtIdx] <= 1'b1;
        entryLine[tgtIdx]  <= stLine;
        entryData[tgtIdx]  <= newData;
        entryWE[tgtIdx]    <= newWE;
      end
    end
  end

  assign bus.stReady       = stReadyS;
  assign bus.dcWriteReq    = dcWriteReqS;
  assign bus.dcWriteAddr   = {entryLine[headPtr], {OFF_BITS{1'b0}}};
  assign bus.dcWriteData   = entryData[headPtr];
  assign bus.dcWriteByteWE = entryWE[headPtr];
  assign bus.fwdHit        = |fwdMaskS;
  assign bus.fwdData       = fwdDataS;
  assign bus.fwdByteMask   = fwdMaskS;
  assign count             = countR;
  assign empty             = (countR == CNT_ZERO) && (state == IDLE);

endmodule

// File: tb/tb_store_write_combine_buffer.sv
// Directed bench for store_write_combine_buffer: expected drained lines are
// queued as stores are issued and compared when the buffer requests them.
module tb_store_write_combine_buffer;

  localparam int AW = 32;
  localparam int LB = 16;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  we;
  } line_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count;
  logic       empty;

  line_t sb[$];
  int    testsRun    = 0;
  int    testsFailed = 0;

  store_write_combine_buffer_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) bus ();

  store_write_combine_buffer #(
    .ENTRY_NUM(4), .ADDR_WIDTH(AW), .LINE_BYTES(LB),
    .DRAIN_THRESHOLD(2), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushLine(input logic [31:0] a, input logic [127:0] d, input logic [15:0] w);
    line_t e;
    e.addr = a;
    e.data = d;
    e.we   = w;
    sb.push_back(e);
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic expReady);
    bus.stAddr   = a;
    bus.stData   = d;
    bus.stByteWE = w;
    bus.stValid  = 1'b1;
    #1;
    check({tag, "_ready"}, 128'(bus.stReady), 128'(expReady));
    tick();
    bus.stValid = 1'b0;
  endtask

  task automatic waitReq(input string tag, input int bound);
    int n = 0;
    while (bus.dcWriteReq !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 128'(bus.dcWriteReq), 128'd1);
  endtask

  task automatic checkHead(input string tag);
    line_t e;
    testsRun++;
    assert (sb.size() > 0) else begin
      testsFailed++;
      $error("FAIL %s_sb: observed empty scoreboard expected a queued line", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_addr"}, 128'(bus.dcWriteAddr), 128'(e.addr));
      check({tag, "_data"}, bus.dcWriteData, e.data);
      check({tag, "_we"}, 128'(bus.dcWriteByteWE), 128'(e.we));
    end
  endtask

  task automatic ackLine(input string tag);
    waitReq(tag, 40);
    checkHead(tag);
    bus.dcWriteAck = 1'b1;
    tick();
    bus.dcWriteAck = 1'b0;
  endtask

  initial begin
    bit sawReq;
    bus.stValid    = 1'b0;
    bus.stAddr     = 32'h0;
    bus.stData     = 32'h0;
    bus.stByteWE   = 4'h0;
    bus.fenceReq   = 1'b0;
    bus.dcWriteAck = 1'b0;
    bus.fwdAddr    = 32'h0;

    // reset state
    #12;
    check("rst_ready", 128'(bus.stReady), 128'd0);
    check("rst_req", 128'(bus.dcWriteReq), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_empty", 128'(empty), 128'd1);
    check("rst_fwd", 128'(bus.fwdHit), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // merge two stores into one line, drained by idle timeout
    store("m_st0", 32'h100, 32'h1122_3344, 4'hF, 1'b1);
    store("m_st1", 32'h104, 32'hAABB_CCDD, 4'h3, 1'b1);
    check("m_count", 128'(count), 128'd1);
    bus.fwdAddr = 32'h104;
    #1;
    check("m_fwd_hit", 128'(bus.fwdHit), 128'd1);
    check("m_fwd_mask", 128'(bus.fwdByteMask), 128'h3);
    check("m_fwd_data", 128'(bus.fwdData), 128'h0000_CCDD);
    pushLine(32'h100, 128'h0000_CCDD_1122_3344, 16'h003F);
    repeat (4) tick();
    check("m_noearly", 128'(bus.dcWriteReq), 128'd0);
    ackLine("m_d0");
    check("m_count0", 128'(count), 128'd0);
    check("m_empty", 128'(empty), 128'd1);

    // threshold drain, stability under held ack, back-to-back drain
    pushLine(32'h100, 128'hA1A2_A3A4, 16'h000F);
    pushLine(32'h200, 128'hB1B2_B3B4, 16'h000F);
    pushLine(32'h300, 128'hC1C2_C3C4, 16'h000F);
    store("t_st0", 32'h100, 32'hA1A2_A3A4, 4'hF, 1'b1);
    store("t_st1", 32'h200, 32'hB1B2_B3B4, 4'hF, 1'b1);
    check("t_req0", 128'(bus.dcWriteReq), 128'd0);
    tick();
    check("t_req1", 128'(bus.dcWriteReq), 128'd1);
    check("t_addr0", 128'(bus.dcWriteAddr), 128'h100);
    store("t_st2", 32'h300, 32'hC1C2_C3C4, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t_hold_req", 128'(bus.dcWriteReq), 128'd1);
      check("t_hold_addr", 128'(bus.dcWriteAddr), 128'h100);
      check("t_hold_we", 128'(bus.dcWriteByteWE), 128'h000F);
      tick();
    end
    ackLine("t_d0");
    check("t_next_req", 128'(bus.dcWriteReq), 128'd1);
    check("t_next_addr", 128'(bus.dcWriteAddr), 128'h200);
    ackLine("t_d1");
    check("t_idle_req", 128'(bus.dcWriteReq), 128'd0);
    ackLine("t_d2");
    check("t_count0", 128'(count), 128'd0);

    // full buffer, merge while full, locked head allocates on simultaneous ack
    pushLine(32'h000, 128'h1010_1010, 16'h000F);
    pushLine(32'h100, 128'h0000_00EE_2020_2020, 16'h001F);
    pushLine(32'h200, 128'h3030_3030, 16'h000F);
    pushLine(32'h300, 128'h4040_4040, 16'h000F);
    pushLine(32'h100, 128'h0000_0000_5566_0000_0000_0000_0000_0000, 16'h0C00);
    store("f_st0", 32'h000, 32'h1010_1010, 4'hF, 1'b1);
    store("f_st1", 32'h100, 32'h2020_2020, 4'hF, 1'b1);
    store("f_st2", 32'h200, 32'h3030_3030, 4'hF, 1'b1);
    store("f_st3", 32'h300, 32'h4040_4040, 4'hF, 1'b1);
    check("f_count4", 128'(count), 128'd4);
    check("f_req", 128'(bus.dcWriteReq), 128'd1);
    bus.stAddr = 32'h400;
    #1;
    check("f_ready_400", 128'(bus.stReady), 128'd0);
    bus.stAddr = 32'h000;
    #1;
    check("f_ready_locked", 128'(bus.stReady), 128'd0);
    bus.stAddr = 32'h104;
    #1;
    check("f_ready_104", 128'(bus.stReady), 128'd1);
    store("f_merge", 32'h104, 32'h0000_00EE, 4'h1, 1'b1);
    check("f_count_merge", 128'(count), 128'd4);
    ackLine("f_d0");
    check("f_count3", 128'(count), 128'd3);
    checkHead("f_d1");
    bus.stAddr     = 32'h108;
    bus.stData     = 32'h5566_7788;
    bus.stByteWE   = 4'b1100;
    bus.stValid    = 1'b1;
    bus.dcWriteAck = 1'b1;
    #1;
    check("f_lock_ready", 128'(bus.stReady), 128'd1);
    tick();
    bus.stValid    = 1'b0;
    bus.dcWriteAck = 1'b0;
    check("f_lock_count", 128'(count), 128'd3);
    ackLine("f_d2");
    ackLine("f_d3");
    ackLine("f_d4");
    check("f_count0", 128'(count), 128'd0);
    check("f_empty", 128'(empty), 128'd1);

    // fence drains everything and blocks stores meanwhile
    pushLine(32'h000, 128'h0101_0101, 16'h000F);
    pushLine(32'h100, 128'h0202_0202, 16'h000F);
    pushLine(32'h200, 128'h0303_0303, 16'h000F);
    store("fn_st0", 32'h000, 32'h0101_0101, 4'hF, 1'b1);
    store("fn_st1", 32'h100, 32'h0202_0202, 4'hF, 1'b1);
    store("fn_st2", 32'h200, 32'h0303_0303, 4'hF, 1'b1);
    bus.fenceReq = 1'b1;
    tick();
    bus.fenceReq = 1'b0;
    bus.stAddr   = 32'h200;
    #1;
    check("fn_ready0", 128'(bus.stReady), 128'd0);
    ackLine("fn_d0");
    check("fn_ready1", 128'(bus.stReady), 128'd0);
    ackLine("fn_d1");
    check("fn_stay", 128'(bus.dcWriteReq), 128'd1);
    check("fn_ready2", 128'(bus.stReady), 128'd0);
    ackLine("fn_d2");
    check("fn_count0", 128'(count), 128'd0);
    check("fn_empty", 128'(empty), 128'd1);
    check("fn_ready3", 128'(bus.stReady), 128'd1);

    // fence on an empty buffer is ignored; then forwarding across a locked head
    bus.fenceReq = 1'b1;
    tick();
    bus.fenceReq = 1'b0;
    store("fw_st0", 32'h100, 32'h0000_0011, 4'b0001, 1'b1);
    waitReq("fw_lock", 40);
    store("fw_st1", 32'h100, 32'h0000_3322, 4'b0011, 1'b1);
    check("fw_count", 128'(count), 128'd2);
    bus.fwdAddr = 32'h100;
    #1;
    check("fw_hit", 128'(bus.fwdHit), 128'd1);
    check("fw_mask", 128'(bus.fwdByteMask), 128'h3);
    check("fw_data", 128'(bus.fwdData), 128'h0000_3322);
    bus.fwdAddr = 32'h108;
    #1;
    check("fw_miss_hit", 128'(bus.fwdHit), 128'd0);
    check("fw_miss_mask", 128'(bus.fwdByteMask), 128'h0);
    check("fw_miss_data", 128'(bus.fwdData), 128'h0);

    // reset in the middle of an outstanding request
    bus.fwdAddr = 32'h100;
    #2;
    rst = 1'b0;
    #1;
    check("r_req", 128'(bus.dcWriteReq), 128'd0);
    check("r_count", 128'(count), 128'd0);
    check("r_empty", 128'(empty), 128'd1);
    check("r_ready", 128'(bus.stReady), 128'd0);
    check("r_fwd", 128'(bus.fwdHit), 128'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sawReq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sawReq = sawReq | bus.dcWriteReq;
      tick();
    end
    check("r_quiet", 128'(sawReq), 128'd0);
    pushLine(32'h300, 128'hDEAD_BEEF, 16'h000F);
    store("r_st0", 32'h300, 32'hDEAD_BEEF, 4'hF, 1'b1);
    ackLine("r_d0");
    check("r_count0", 128'(count), 128'd0);
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
